dac_transmitter: RTL

- Consumes the 11-bit sign-magnitude output sample from the effects stage once per sample period.
- Converts it to 12-bit offset-binary and serializes it as a 16-bit SPI write frame to an external 12-bit DAC (MCP4921-class).
- It is the output-side counterpart of the effects engine.
- Frame start is timed off the shared per-sample slot counter, so the effects result is guaranteed settled.

---
 rtl/dac_transmitter_if.sv | 34 +++
 rtl/dac_transmitter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dac_transmitter_if.sv
// Sample-in / SPI-out bundle between the effects stage, the DAC transmitter and the DAC pins.
// master: the transmitter side. slave: the effects stage and DAC pin side.
interface dac_transmitter_if;
    logic [9:0]  counter;
    logic [10:0] sendVoltage;
    logic        csn;
    logic        sclk;
    logic        mosi;
    logic        ldac_n;
    logic        busy;
    logic        overrun;

    modport master (
        input  counter,
        input  sendVoltage,
        output csn,
        output sclk,
        output mosi,
        output ldac_n,
        output busy,
        output overrun
    );

    modport slave (
        output counter,
        output sendVoltage,
        input  csn,
        input  sclk,
        input  mosi,
        input  ldac_n,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/dac_transmitter.sv
// Converts the 11-bit sign-magnitude sample to 12-bit offset binary and sends it as a 16-bit SPI frame.
// Latency: csn falls 1 clk after the counter==LOAD_SLOT edge. The frame is 32*CLK_DIV clk long, then a CLK_DIV gap.
// No backpressure: a load slot that arrives while busy is dropped and sets sticky overrun. DAC_LDAC_EN adds an ldac_n pulse.
module dac_transmitter #(
    parameter int         CLK_DIV     = 4,
    parameter logic [9:0] LOAD_SLOT   = 10'h5,
    parameter logic [3:0] CONFIG      = 4'b0111,
    parameter int         LDAC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    dac_transmitter_if.master dac
);

    // One counter serves the sclk divider, the GAP timer and the LDAC timer.
    localparam int CNT_MAX = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [3:0]    bit_dec;
    logic [15:0]   shreg_q, shreg_d;
    logic          csn_q, csn_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          ovr_q, ovr_d;
    logic          load_hit;
    logic          div_wrap;
    logic [11:0]   mag2;
    logic [11:0]   code;
    logic [15:0]   frame;

`ifdef DAC_LDAC_EN
    logic ldac_q, ldac_d;
    assign dac.ldac_n = ldac_q;
`else
    assign dac.ldac_n = 1'b0;
`endif

    assign load_hit = (dac.counter == LOAD_SLOT);
    assign div_wrap = (div_q == DIV_LAST);
    assign bit_dec  = bit_q - 4'd1;

    // The doubled magnitude is at most 2046, so the offset code stays within 2..4094 and needs no clamp.
    always_comb begin
        mag2  = {1'b0, dac.sendVoltage[9:0], 1'b0};
        code  = dac.sendVoltage[10] ? (12'h800 - mag2) : (12'h800 + mag2);
        frame = {CONFIG, code};
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        csn_d   = csn_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ovr_d   = ovr_q | (load_hit && (state_q != IDLE));
`ifdef DAC_LDAC_EN
        ldac_d  = ldac_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_hit) begin
                    shreg_d = frame;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = frame[15];
                    div_d   = '0;
                    bit_d   = 4'd15;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Data moves only on the falling edge so it is stable around the DAC's rising-edge sample.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            csn_d   = 1'b1;
                            mosi_d  = 1'b0;
                            state_d = GAP;
                        end else begin
                            bit_d  = bit_dec;
                            mosi_d = shreg_q[bit_dec];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_wrap) begin
                    div_d = '0;
`ifdef DAC_LDAC_EN
                    ldac_d  = 1'b0;
                    state_d = LDAC;
`else
                    state_d = IDLE;
`endif
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LDAC: begin
                if (div_q == LDAC_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
`ifdef DAC_LDAC_EN
                    ldac_d  = 1'b1;
`endif
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 4'd15;
            shreg_q <= '0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ovr_q   <= ovr_d;
`ifdef DAC_LDAC_EN
            ldac_q  <= ldac_d;
`endif
        end
    end

    assign dac.csn     = csn_q;
    assign dac.sclk    = sclk_q;
    assign dac.mosi    = mosi_q;
    assign dac.busy    = (state_q != IDLE);
    assign dac.overrun = ovr_q;

endmodule
